// File: rtl/cbfp_pkg.sv
// ----------------------------------------------------------------------------
// cbfp_pkg
// Shared types for the CBFP scale-index path of the FFT stage.
//   CBFP_IDX_W   : width of one scale index (I or Q exponent)
//   cbfp_idx_t   : one scale index
//   piso_state_t : states of the index parallel-in/serial-out unloader
// ----------------------------------------------------------------------------
package cbfp_pkg;

    localparam int CBFP_IDX_W = 5;

    typedef logic [CBFP_IDX_W-1:0] cbfp_idx_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } piso_state_t;

endpackage

// File: rtl/cbfp_min_tree.sv
// ----------------------------------------------------------------------------
// cbfp_min_tree
// Purely combinational unsigned minimum over N scale indices, built as a
// balanced pairwise compare tree (log2(N) compare levels).
//   vals    : in  W x [N]  indices to reduce
//   min_val : out W        smallest value in vals
// ----------------------------------------------------------------------------
module cbfp_min_tree
    import cbfp_pkg::*;
#(
    parameter int N = 8,
    parameter int W = CBFP_IDX_W
) (
    input  logic [W-1:0] vals [N],
    output logic [W-1:0] min_val
);

    localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
    localparam int P      = 1 << LEVELS;

    always_comb begin : min_reduce
        logic [W-1:0] node [P];
        // Leaves beyond N are padded with all-ones so they never win a compare.
        for (int k = 0; k < P; k++) begin
            node[k] = '1;
        end
        for (int k = 0; k < N; k++) begin
            node[k] = vals[k];
        end
        // Each level halves the live width; results are packed to the low end,
        // which is safe because slot k is only written after 2k and 2k+1 are read.
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < (P >> (l + 1)); k++) begin
                node[k] = (node[2*k+1] < node[2*k]) ? node[2*k+1] : node[2*k];
            end
        end
        min_val = node[0];
    end

endmodule

// File: rtl/cbfp_idx_piso.sv
// ----------------------------------------------------------------------------
// cbfp_idx_piso
// Parallel-in / serial-out unloader for CBFP scale-index pairs. A whole block
// of REG_DEPTH (I,Q) pairs is taken in one cycle and replayed one pair per
// beat, oldest (element REG_DEPTH-1) first, over a valid/ready handshake.
// A new block may be accepted on the last-beat accept for zero-bubble
// back-to-back operation.
//
// Ports:
//   clk, rstn   : clock (rising edge), asynchronous active-low reset
//   load_valid  : in  parallel block present
//   load_ready  : out block accepted when load_valid && load_ready
//   load_i/q    : in  DATA_WIDTH x [0:REG_DEPTH-1], element REG_DEPTH-1 oldest
//   out_valid   : out serial beat valid
//   out_ready   : in  downstream accepts beat
//   out_i/q     : out current index pair
//   out_idx     : out beat number within block
//   out_last    : out high on beat REG_DEPTH-1
//   busy        : out unloader in SHIFT
//   blk_min     : out (only with CBFP_BLK_MIN_EN) unsigned minimum of the
//                 2*REG_DEPTH indices of the most recently loaded block
//
// Optional feature macro: CBFP_BLK_MIN_EN
// ----------------------------------------------------------------------------
module cbfp_idx_piso
    import cbfp_pkg::*;
#(
    parameter int DATA_WIDTH = CBFP_IDX_W,
    parameter int REG_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [DATA_WIDTH-1:0]    load_i [0:REG_DEPTH-1],
    input  logic [DATA_WIDTH-1:0]    load_q [0:REG_DEPTH-1],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_i,
    output logic [DATA_WIDTH-1:0]    out_q,
    output logic [$clog2(REG_DEPTH)-1:0] out_idx,
    output logic                     out_last,
    output logic                     busy
`ifdef CBFP_BLK_MIN_EN
    ,
    output logic [DATA_WIDTH-1:0]    blk_min
`endif
);

    localparam int               CNT_W    = $clog2(REG_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REG_DEPTH - 1);

    piso_state_t             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   sreg_i_q [0:REG_DEPTH-1];
    logic [DATA_WIDTH-1:0]   sreg_i_d [0:REG_DEPTH-1];
    logic [DATA_WIDTH-1:0]   sreg_q_q [0:REG_DEPTH-1];
    logic [DATA_WIDTH-1:0]   sreg_q_d [0:REG_DEPTH-1];
    logic                    last_beat;

    assign last_beat = (cnt_q == LAST_CNT);

    // Outputs come straight from the registers, so nothing on load_* can
    // reach out_*. Registers are zero in IDLE, which gives zero out_i/out_q.
    assign out_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign out_i     = sreg_i_q[REG_DEPTH-1];
    assign out_q     = sreg_q_q[REG_DEPTH-1];
    assign out_idx   = cnt_q;
    assign out_last  = (state_q == SHIFT) && last_beat;

    // Next-state logic. load_ready depends on out_ready only on the last beat
    // so a fresh block can follow the old one without a bubble.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_i_d   = sreg_i_q;
        sreg_q_d   = sreg_q_q;
        load_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                if (out_ready) begin
                    if (last_beat) begin
                        load_ready = 1'b1;
                        state_d    = IDLE;
                        cnt_d      = '0;
                        for (int j = 0; j < REG_DEPTH; j++) begin
                            sreg_i_d[j] = '0;
                            sreg_q_d[j] = '0;
                        end
                    end else begin
                        for (int j = REG_DEPTH - 1; j > 0; j--) begin
                            sreg_i_d[j] = sreg_i_q[j-1];
                            sreg_q_d[j] = sreg_q_q[j-1];
                        end
                        sreg_i_d[0] = '0;
                        sreg_q_d[0] = '0;
                        cnt_d       = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load overrides the return-to-IDLE of a finishing block.
        if (load_valid && load_ready) begin
            state_d = SHIFT;
            cnt_d   = '0;
            for (int j = 0; j < REG_DEPTH; j++) begin
                sreg_i_d[j] = load_i[j];
                sreg_q_d[j] = load_q[j];
            end
        end
    end

    // State, beat counter and the two index shift registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int j = 0; j < REG_DEPTH; j++) begin
                sreg_i_q[j] <= '0;
                sreg_q_q[j] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sreg_i_q <= sreg_i_d;
            sreg_q_q <= sreg_q_d;
        end
    end

`ifdef CBFP_BLK_MIN_EN
    logic [DATA_WIDTH-1:0] min_in [2*REG_DEPTH];
    logic [DATA_WIDTH-1:0] load_min;
    logic [DATA_WIDTH-1:0] blk_min_q, blk_min_d;

    // I indices occupy the low half of the tree input, Q the high half.
    always_comb begin
        for (int j = 0; j < REG_DEPTH; j++) begin
            min_in[j]             = load_i[j];
            min_in[REG_DEPTH + j] = load_q[j];
        end
    end

    cbfp_min_tree #(
        .N (2 * REG_DEPTH),
        .W (DATA_WIDTH)
    ) u_min_tree (
        .vals    (min_in),
        .min_val (load_min)
    );

    // Block minimum is captured with the block and survives the return to IDLE.
    always_comb begin
        blk_min_d = blk_min_q;
        if (load_valid && load_ready) begin
            blk_min_d = load_min;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_min_q <= '0;
        end else begin
            blk_min_q <= blk_min_d;
        end
    end

    assign blk_min = blk_min_q;
`endif

endmodule

// File: tb/tb_cbfp_idx_piso.sv
// ----------------------------------------------------------------------------
// tb_cbfp_idx_piso
// Self-checking bench for cbfp_idx_piso. A queue of expected beats is filled
// with each accepted block (oldest element first) and drained on each accepted
// beat; DUT outputs are compared against it every cycle.
// Optional feature macro: CBFP_BLK_MIN_EN
// ----------------------------------------------------------------------------
module tb_cbfp_idx_piso;

    localparam int DW = 5;
    localparam int RD = 4;

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        int            idx;
    } beat_t;

    logic          clk;
    logic          rstn;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] ld_i [0:RD-1];
    logic [DW-1:0] ld_q [0:RD-1];
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_i;
    logic [DW-1:0] out_q;
    logic [1:0]    out_idx;
    logic          out_last;
    logic          busy;
`ifdef CBFP_BLK_MIN_EN
    logic [DW-1:0] blk_min;
`endif

    beat_t         exp_q [$];
    logic [DW-1:0] mdl_min;
    int            vectors;
    int            miscompares;
    logic [15:0]   obs;
    logic [15:0]   expv;

    cbfp_idx_piso #(
        .DATA_WIDTH (DW),
        .REG_DEPTH  (RD)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_i     (ld_i),
        .load_q     (ld_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_i      (out_i),
        .out_q      (out_q),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy)
`ifdef CBFP_BLK_MIN_EN
        ,
        .blk_min    (blk_min)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {out_valid, busy, out_last, load_ready, out_idx, out_i, out_q}.
    function automatic logic [15:0] model_outputs();
        logic is_last;
        if (exp_q.size() == 0) begin
            return {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 5'd0};
        end
        is_last = (exp_q.size() == 1);
        return {1'b1, 1'b1, is_last, is_last && out_ready,
                2'(exp_q[0].idx), exp_q[0].i, exp_q[0].q};
    endfunction

    function automatic logic [15:0] observed();
        return {out_valid, busy, out_last, load_ready, out_idx, out_i, out_q};
    endfunction

    task automatic set_inputs(input bit lv, input bit ordy);
        @(negedge clk);
        load_valid = lv;
        out_ready  = ordy;
        #1;
    endtask

    task automatic set_block(input int a0, input int a1, input int a2, input int a3,
                             input int b0, input int b1, input int b2, input int b3);
        ld_i[0] = DW'(a0); ld_i[1] = DW'(a1); ld_i[2] = DW'(a2); ld_i[3] = DW'(a3);
        ld_q[0] = DW'(b0); ld_q[1] = DW'(b1); ld_q[2] = DW'(b2); ld_q[3] = DW'(b3);
    endtask

    task automatic set_random_block();
        for (int j = 0; j < RD; j++) begin
            ld_i[j] = DW'($urandom_range(0, 31));
            ld_q[j] = DW'($urandom_range(0, 31));
        end
    endtask

    // Advance one clock, updating the reference from the handshakes seen now.
    task automatic tick();
        bit beat_acc;
        bit load_acc;
        beat_acc = rstn && (exp_q.size() != 0) && out_ready;
        load_acc = rstn && load_valid &&
                   ((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
        if (beat_acc) void'(exp_q.pop_front());
        if (load_acc) begin
            logic [DW-1:0] m;
            m = '1;
            for (int j = RD - 1; j >= 0; j--) begin
                beat_t b;
                b.i   = ld_i[j];
                b.q   = ld_q[j];
                b.idx = RD - 1 - j;
                exp_q.push_back(b);
                if (ld_i[j] < m) m = ld_i[j];
                if (ld_q[j] < m) m = ld_q[j];
            end
            mdl_min = m;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rstn       = 1'b1;
        load_valid = 1'b0;
        out_ready  = 1'b1;
        set_block(1, 2, 3, 4, 5, 6, 7, 8);
        #2 rstn = 1'b0;
        exp_q.delete();
        mdl_min = '0;
        for (int c = 0; c < 3; c++) begin
            set_inputs(1'b1, 1'b1);
            obs = observed(); expv = model_outputs(); vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL reset cyc%0d got %h want %h", c, obs, expv);
            end
            tick();
        end
        set_inputs(1'b0, 1'b1);
        rstn = 1'b1;
        #1;
        obs = observed(); expv = model_outputs(); vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL reset_release got %h want %h", obs, expv);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] got_i [$];
        logic [DW-1:0] got_q [$];
        logic [DW-1:0] want_i [4];
        logic [DW-1:0] want_q [4];
        want_i = '{5'd9, 5'd1, 5'd7, 5'd3};
        want_q = '{5'd8, 5'd6, 5'd4, 5'd2};
        set_block(3, 7, 1, 9, 2, 4, 6, 8);
        for (int c = 0; c < 7; c++) begin
            set_inputs(c == 0, 1'b1);
            obs = observed(); expv = model_outputs(); vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL basic cyc%0d got %h want %h", c, obs, expv);
            end
            if (out_valid) begin
                got_i.push_back(out_i);
                got_q.push_back(out_q);
            end
            tick();
        end
        vectors++;
        if (got_i.size() != 4) begin
            miscompares++;
            $display("[TB] FAIL basic_count got %0d beats want 4", got_i.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (got_i[k] !== want_i[k] || got_q[k] !== want_q[k]) begin
                    miscompares++;
                    $display("[TB] FAIL basic_seq beat%0d got %0d/%0d want %0d/%0d",
                             k, got_i[k], got_q[k], want_i[k], want_q[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got_i [$];
        logic [DW-1:0] want_i [4];
        want_i = '{5'd9, 5'd1, 5'd7, 5'd3};
        set_block(3, 7, 1, 9, 2, 4, 6, 8);
        for (int c = 0; c < 10; c++) begin
            set_inputs(c == 0, !(c >= 2 && c <= 4));
            obs = observed(); expv = model_outputs(); vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL backpressure cyc%0d got %h want %h", c, obs, expv);
            end
            if (c >= 2 && c <= 4) begin
                vectors++;
                if (out_i !== 5'd1 || out_idx !== 2'd1) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold cyc%0d got i=%0d idx=%0d want i=1 idx=1",
                             c, out_i, out_idx);
                end
            end
            if (out_valid && out_ready) got_i.push_back(out_i);
            tick();
        end
        vectors++;
        if (got_i.size() != 4 || got_i[0] !== want_i[0] || got_i[1] !== want_i[1] ||
            got_i[2] !== want_i[2] || got_i[3] !== want_i[3]) begin
            miscompares++;
            $display("[TB] FAIL backpressure_seq got %0d beats want 9,1,7,3", got_i.size());
        end
    endtask

    task automatic test_back_to_back();
        set_random_block();
        for (int c = 0; c < 10; c++) begin
            set_inputs(c <= 4, 1'b1);
            if (c == 1) set_block(5, 5, 5, 0, 1, 2, 3, 4);
            obs = observed(); expv = model_outputs(); vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL back_to_back cyc%0d got %h want %h", c, obs, expv);
            end
            if (c == 5) begin
                vectors++;
                if (out_valid !== 1'b1 || out_i !== 5'd0 || out_idx !== 2'd0) begin
                    miscompares++;
                    $display("[TB] FAIL no_bubble got v=%0d i=%0d idx=%0d want v=1 i=0 idx=0",
                             out_valid, out_i, out_idx);
                end
            end
            tick();
        end
    endtask

    task automatic test_reject_mid();
        set_random_block();
        for (int c = 0; c < 7; c++) begin
            set_inputs(c == 0 || c == 2, 1'b1);
            if (c == 2) set_random_block();
            obs = observed(); expv = model_outputs(); vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL reject_mid cyc%0d got %h want %h", c, obs, expv);
            end
            if (c == 2) begin
                vectors++;
                if (load_ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL reject_ready got %0d want 0", load_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_random_block();
        for (int c = 0; c < 3; c++) begin
            set_inputs(c == 0, 1'b1);
            tick();
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        exp_q.delete();
        mdl_min = '0;
        vectors++;
        if (out_valid !== 1'b0 || out_i !== 5'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid got v=%0d i=%0d busy=%0d want 0/0/0",
                     out_valid, out_i, busy);
        end
        tick();
        set_inputs(1'b0, 1'b1);
        rstn = 1'b1;
        #1;
        obs = observed(); expv = model_outputs(); vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_release got %h want %h", obs, expv);
        end
        tick();
    endtask

`ifdef CBFP_BLK_MIN_EN
    task automatic test_blk_min();
        set_block(3, 7, 1, 9, 2, 4, 6, 8);
        for (int c = 0; c < 7; c++) begin
            set_inputs(c == 0, 1'b1);
            if (c >= 1) begin
                vectors++;
                if (blk_min !== 5'd1 || blk_min !== mdl_min) begin
                    miscompares++;
                    $display("[TB] FAIL blk_min cyc%0d got %0d want 1", c, blk_min);
                end
            end
            tick();
        end
        set_block(31, 31, 31, 31, 31, 31, 31, 31);
        set_inputs(1'b1, 1'b1);
        tick();
        set_inputs(1'b0, 1'b1);
        vectors++;
        if (blk_min !== 5'd31) begin
            miscompares++;
            $display("[TB] FAIL blk_min_all31 got %0d want 31", blk_min);
        end
        for (int c = 0; c < 5; c++) tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_inputs($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
            set_random_block();
            obs = observed(); expv = model_outputs(); vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL random cyc%0d got %h want %h", c, obs, expv);
            end
`ifdef CBFP_BLK_MIN_EN
            vectors++;
            if (blk_min !== mdl_min) begin
                miscompares++;
                $display("[TB] FAIL random_min cyc%0d got %0d want %0d", c, blk_min, mdl_min);
            end
`endif
            tick();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mdl_min     = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reject_mid();
        test_reset_mid();
`ifdef CBFP_BLK_MIN_EN
        test_blk_min();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cbfp_idx_piso.md
Name: cbfp_idx_piso

Overview:
- Parallel-in / serial-out unloader for CBFP scale indices (I and Q exponent pairs).
- Accepts a full block of REG_DEPTH index pairs in one cycle, as captured by the index shift-register front end.
- Replays the pairs one per beat, oldest first, to the downstream scaling/normalisation stage over a valid/ready handshake.
- Sits between the CBFP index collection shift register and the per-sample shift/normalise unit of the FFT stage.

Parameters:
- DATA_WIDTH, 5, width of one scale index (I or Q).
- REG_DEPTH, 4, number of index pairs per block; must be >= 2.
- CNT_W, $clog2(REG_DEPTH), localparam, beat counter width; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- load_valid  in  1  parallel block present.
- load_ready  out  1  block accepted when load_valid && load_ready.
- load_i  in  DATA_WIDTH x [0:REG_DEPTH-1]  I indices; element REG_DEPTH-1 is oldest.
- load_q  in  DATA_WIDTH x [0:REG_DEPTH-1]  Q indices, same ordering.
- out_valid  out  1  serial beat valid.
- out_ready  in  1  downstream accepts beat.
- out_i  out  DATA_WIDTH  current I index.
- out_q  out  DATA_WIDTH  current Q index.
- out_idx  out  CNT_W  beat number within block, 0..REG_DEPTH-1.
- out_last  out  1  high on beat REG_DEPTH-1.
- busy  out  1  state == SHIFT.

Behaviour:
- Reset (rstn low, async): all shift registers 0, cnt 0, state IDLE; out_valid 0, out_i/out_q 0, out_idx 0, out_last 0, busy 0. load_ready reads 1, but load_valid is ignored while rstn is low.
- A reset asserted mid-block discards the remaining beats. There is no partial-block recovery.
- FSM states: IDLE and SHIFT.
- IDLE:
  - load_ready = 1.
  - On load: sreg_i[j] <= load_i[j] and sreg_q[j] <= load_q[j] for all j; cnt <= 0; state <= SHIFT.
- SHIFT:
  - out_valid = 1; out_i = sreg_i[REG_DEPTH-1]; out_q = sreg_q[REG_DEPTH-1]; out_idx = cnt; out_last = (cnt == REG_DEPTH-1).
  - All of these are driven directly from registers; there is no combinational path from load_* to out_*.
- Beat accept (out_valid && out_ready, not last):
  - sreg[j+1] <= sreg[j] for j = 0..REG_DEPTH-2; sreg[0] <= 0; cnt <= cnt+1.
- Beat stall (out_ready = 0): all registers hold; out_* stable. No beat is dropped or repeated.
- Last-beat accept:
  - load_ready = out_valid && out_ready && out_last. This is a combinational path from out_ready, and it is the only such path.
  - If load_valid is also high: load the new block, cnt <= 0, stay in SHIFT. The next cycle carries beat 0 of the new block with zero bubble.
  - Otherwise: state <= IDLE and registers cleared to 0.
- load_valid asserted in SHIFT outside the last-beat accept: load_ready = 0, no effect. Upstream must hold the block.
- Latency: block accepted at cycle N -> beat 0 valid at N+1. Beat k appears no earlier than N+1+k.
- Throughput: with out_ready held high, one beat per cycle continuously (REG_DEPTH beats per block).
- Emission order: oldest first (load element REG_DEPTH-1 first, element 0 last). This restores the arrival order of the collecting shift register.

Optional Feature:
- Macro CBFP_BLK_MIN_EN.
- When defined:
  - Extra output port blk_min (DATA_WIDTH): the unsigned minimum of all 2*REG_DEPTH loaded indices (I and Q).
  - Registered on every load accept and held until the next load.
  - Reset value 0; not cleared on return to IDLE.
  - Valid from the cycle beat 0 is presented.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cbfp_pkg:
  - CBFP_IDX_W = 5.
  - typedef logic [CBFP_IDX_W-1:0] cbfp_idx_t.
  - typedef enum logic {IDLE, SHIFT} piso_state_t.
- Sub-module cbfp_min_tree: combinational unsigned minimum over N indices, a balanced compare tree. Instantiated only under CBFP_BLK_MIN_EN.

Test Plan:
- Basic block: load_i = {3,7,1,9} (elements 0..3), load_q = {2,4,6,8}, out_ready = 1.
  - out_i = 9,1,7,3 and out_q = 8,6,4,2 on consecutive cycles starting at N+1.
  - out_idx = 0..3; out_last only on the 4th beat; then IDLE with out_valid = 0.
- Backpressure: out_ready = 0 for 3 cycles at beat 1.
  - out_i holds 1, out_idx holds 1; sequence resumes 7,3 with no skip or duplicate.
- Back-to-back: second block {5,5,5,0} held with load_valid during first block's last beat.
  - Accepted on that cycle; next cycle out_valid = 1, out_i = 0, out_idx = 0 (no bubble).
- Load rejected mid-block: load_valid pulsed at beat 1.
  - load_ready = 0 and first-block sequence is unaffected.
- Reset mid-SHIFT: rstn low at beat 2.
  - Immediately out_valid = 0, out_i = 0, busy = 0. After release, IDLE with load_ready = 1.
- CBFP_BLK_MIN_EN: basic-block values.
  - blk_min = 1 from beat 0 until the next load. Reloading with all 31 gives blk_min = 31.
